// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between ALU writeback and load return.
// Loads win by default; a saturating starvation counter forces an ALU win after STARVE_LIMIT losses.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_address,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [1:0]            grant_src
);

  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_ALU  = 2'b01;
  localparam logic [1:0] GRANT_MEM  = 2'b10;

  logic [3:0] starve_cnt;
  logic       alu_turn;
  logic       active;

  assign alu_turn = (starve_cnt == LIMIT);
  assign active   = reset & clk_enable;

  // Readies depend only on enable, reset, both valids and the starve counter.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (active) begin
      if (alu_valid && mem_valid) begin
        alu_ready = alu_turn;
        mem_ready = !alu_turn;
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (clk_enable) begin
      if (alu_valid && !alu_ready) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // A write to register 0 is consumed as a grant but never strobed into the file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_write_enable  <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
      grant_src        <= GRANT_NONE;
    end else if (alu_ready) begin
      rf_write_enable  <= (alu_addr != '0);
      rf_write_address <= alu_addr;
      rf_write_data    <= alu_data;
      grant_src        <= GRANT_ALU;
    end else if (mem_ready) begin
      rf_write_enable  <= (mem_addr != '0);
      rf_write_address <= mem_addr;
      rf_write_data    <= mem_data;
      grant_src        <= GRANT_MEM;
    end else begin
      rf_write_enable  <= 1'b0;
      grant_src        <= GRANT_NONE;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter with STARVE_LIMIT=3.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        rf_write_enable;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_data;
  logic [1:0]  grant_src;

  int checks   = 0;
  int failures = 0;

  regfile_write_arbiter #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (5),
    .STARVE_LIMIT(3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .rf_write_enable (rf_write_enable),
    .rf_write_address(rf_write_address),
    .rf_write_data   (rf_write_data),
    .grant_src       (grant_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input string tag, input logic ea, input logic em);
    chk({tag, "_alu_ready"}, 64'(alu_ready), 64'(ea));
    chk({tag, "_mem_ready"}, 64'(mem_ready), 64'(em));
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic [1:0] g);
    chk({tag, "_we"},    64'(rf_write_enable),  64'(we));
    chk({tag, "_addr"},  64'(rf_write_address), 64'(a));
    chk({tag, "_data"},  64'(rf_write_data),    64'(d));
    chk({tag, "_grant"}, 64'(grant_src),        64'(g));
  endtask

  logic [1:0] pattern [8] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};

  initial begin
    reset = 1'b0; clk_enable = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'hA5A5A5A5;

    // Reset held with both requesters valid
    tick(); tick();
    chk_ready("rst", 1'b0, 1'b0);
    chk_out("rst", 1'b0, 5'd0, 32'd0, 2'b00);

    // Release: MEM wins first contended cycle
    @(negedge clk); reset = 1'b1; #1;
    chk_ready("rel", 1'b0, 1'b1);
    tick();
    chk_out("rel", 1'b1, 5'd3, 32'hA5A5A5A5, 2'b10);
    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk_ready("idle", 1'b0, 1'b0);
    tick();
    chk_out("idle", 1'b0, 5'd3, 32'hA5A5A5A5, 2'b00);

    // Single ALU request
    set_req(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk_ready("alu1", 1'b1, 1'b0);
    tick();
    chk_out("alu1", 1'b1, 5'd5, 32'hDEADBEEF, 2'b01);
    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk_out("alu1_after", 1'b0, 5'd5, 32'hDEADBEEF, 2'b00);

    // Continuous contention: M,M,M,A repeating
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 5'd20, 32'hA100 + 32'(i), 1'b1, 5'(10 + i), 32'hB000 + 32'(i));
      chk_ready($sformatf("cont%0d", i), pattern[i] == 2'b01, pattern[i] == 2'b10);
      tick();
      if (pattern[i] == 2'b10)
        chk_out($sformatf("cont%0d", i), 1'b1, 5'(10 + i), 32'hB000 + 32'(i), 2'b10);
      else
        chk_out($sformatf("cont%0d", i), 1'b1, 5'd20, 32'hA100 + 32'(i), 2'b01);
    end

    // Load to register 0: consumed, not strobed
    set_req(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    chk_ready("zero", 1'b0, 1'b1);
    tick();
    chk_out("zero", 1'b0, 5'd0, 32'h1234, 2'b10);

    // Build counter to 2, then freeze for 4 cycles
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, 5'd21, 32'hC0, 1'b1, 5'(1 + i), 32'hD0 + 32'(i));
      tick();
      chk_out($sformatf("pre_gate%0d", i), 1'b1, 5'(1 + i), 32'hD0 + 32'(i), 2'b10);
    end
    set_req(1'b1, 5'd21, 32'hC0, 1'b1, 5'd4, 32'hE0);
    clk_enable = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk_ready($sformatf("gate%0d", i), 1'b0, 1'b0);
      tick();
      chk_out($sformatf("gate%0d", i), 1'b0, 5'd2, 32'hD1, 2'b00);
      @(negedge clk); #1;
    end
    clk_enable = 1'b1; #1;
    chk_ready("ungate0", 1'b0, 1'b1);
    tick();
    chk_out("ungate0", 1'b1, 5'd4, 32'hE0, 2'b10);
    set_req(1'b1, 5'd21, 32'hC0, 1'b1, 5'd6, 32'hE1);
    chk_ready("ungate1", 1'b1, 1'b0);
    tick();
    chk_out("ungate1", 1'b1, 5'd21, 32'hC0, 2'b01);

    // Asynchronous reset between edges while a write is on the port
    set_req(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    tick();
    chk_out("pre_arst", 1'b1, 5'd9, 32'h99, 2'b10);
    #2 reset = 1'b0;
    #1;
    chk_out("arst", 1'b0, 5'd0, 32'd0, 2'b00);
    chk_ready("arst", 1'b0, 1'b0);

    // Counter restarts from 0 after reset: M,M,M,A
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 5'd30, 32'hF00, 1'b1, 5'(12 + i), 32'hF10 + 32'(i));
      tick();
      if (i < 3)
        chk_out($sformatf("post_rst%0d", i), 1'b1, 5'(12 + i), 32'hF10 + 32'(i), 2'b10);
      else
        chk_out($sformatf("post_rst%0d", i), 1'b1, 5'd30, 32'hF00, 2'b01);
    end

    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
